// File: rtl/memory_load_align_pkg.sv
// Shared encodings for the load-data aligner: access sizes, FSM states and
// the byte-count helper used by the split detector and the extractor.
package load_align_pkg;

  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE   = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF   = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD   = 2'd2;
  localparam logic [SIZE_W-1:0] SZ_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  // A double on a 32-bit bus degrades to a word access.
  function automatic int unsigned size_bytes(input logic [SIZE_W-1:0] size,
                                             input int unsigned       dw);
    case (size)
      SZ_BYTE: return 32'd1;
      SZ_HALF: return 32'd2;
      SZ_WORD: return 32'd4;
      default: return (dw >= 32'd64) ? 32'd8 : 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_load_align_if.sv
// Descriptor, read-beat and response channels between the LSU and the
// load aligner; the aligner uses the slave modport.
interface memory_load_align_if
  import load_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

  logic                  req_valid;
  logic                  req_ready;
  logic [OFF_W-1:0]      req_offset;
  logic [SIZE_W-1:0]     req_size;
  logic                  req_sign;
  logic                  req_split;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_err;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_misalign;

  modport master (
    output req_valid, req_offset, req_size, req_sign,
    output beat_valid, beat_data, beat_err,
    output rsp_ready,
    input  req_ready, req_split, beat_ready,
    input  rsp_valid, rsp_data, rsp_err, rsp_misalign
  );

  modport slave (
    input  req_valid, req_offset, req_size, req_sign,
    input  beat_valid, beat_data, beat_err,
    input  rsp_ready,
    output req_ready, req_split, beat_ready,
    output rsp_valid, rsp_data, rsp_err, rsp_misalign
  );

endinterface

// File: rtl/memory_load_align_extract.sv
// load_data_extract: shifts a two-word window down by the byte offset, keeps
// the accessed bytes and sign/zero-extends them to the bus width.
module load_data_extract
  import load_align_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned OFF_W      = $clog2(DATA_WIDTH / 8),
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic [2*DATA_WIDTH-1:0] merged,
  input  logic [OFF_W-1:0]        offset,
  input  logic [SIZE_W-1:0]       size,
  input  logic                    sign,
  output logic [DATA_WIDTH-1:0]   data
);

  logic [2*DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]   low;
  int unsigned             nbits;
  logic [IDX_W-1:0]        msb_idx;
  logic                    fill;

  // Full-width accesses have no bits above nbits, so sign is ignored there.
  always_comb begin
    shifted = merged >> {offset, 3'b000};
    low     = shifted[DATA_WIDTH-1:0];
    nbits   = 32'd8 * size_bytes(size, DATA_WIDTH);
    msb_idx = IDX_W'(nbits - 32'd1);
    fill    = sign & low[msb_idx];
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      data[i] = (i < int'(nbits)) ? low[i] : fill;
    end
  end

endmodule

// File: rtl/memory_load_align.sv
// Registered load-data aligner: one or two read beats in, aligned/extended
// result out. Define MISALIGN_SPLIT_EN to merge boundary-crossing accesses.
module memory_load_align
  import load_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic               clk,
  input logic               rst_n,
  memory_load_align_if.slave bus
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned OFF_W = $clog2(DW / 8);
  localparam int unsigned BYTES = DW / 8;

  if (!(DW == 32 || DW == 64)) begin : g_bad_width
    $error("memory_load_align: DATA_WIDTH must be 32 or 64");
  end

  state_t            state, state_nxt;
  logic              req_ready, beat_ready, rsp_valid;
  logic              req_fire, beat_fire, rsp_fire;
  logic              split_c, last_beat, err_fin;
  state_t            desc_tgt;

  logic [OFF_W-1:0]  off_q;
  logic [SIZE_W-1:0] size_q;
  logic              sign_q;
  logic [DW-1:0]     rsp_data_q;
  logic              rsp_err_q;
  logic [2*DW-1:0]   merged;
  logic [DW-1:0]     extract_data;

`ifdef MISALIGN_SPLIT_EN
  logic              split_q;
  logic              err_q;
  logic [DW-1:0]     lo_q;
`else
  logic              rsp_misalign_q;
`endif

  // Boundary crossing is a pure function of the descriptor, not of state.
  always_comb begin
    split_c = (32'(bus.req_offset) + size_bytes(bus.req_size, DW)) > BYTES;
  end

  assign req_fire  = bus.req_valid  & req_ready;
  assign beat_fire = bus.beat_valid & beat_ready;
  assign rsp_fire  = rsp_valid      & bus.rsp_ready;

`ifdef MISALIGN_SPLIT_EN
  assign desc_tgt  = WAIT_LO;
  assign last_beat = beat_fire & ((state == WAIT_HI) | ~split_q);
  assign err_fin   = bus.beat_err | ((state == WAIT_HI) & err_q);
  assign merged    = (state == WAIT_HI) ? {bus.beat_data, lo_q}
                                        : {{DW{1'b0}}, bus.beat_data};
`else
  // Crossing descriptors are answered locally without touching the bus.
  assign desc_tgt  = split_c ? RESP : WAIT_LO;
  assign last_beat = beat_fire;
  assign err_fin   = bus.beat_err;
  assign merged    = {{DW{1'b0}}, bus.beat_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_fire)  state_nxt = desc_tgt;
      WAIT_LO: if (beat_fire) state_nxt = last_beat ? RESP : WAIT_HI;
      WAIT_HI: if (beat_fire) state_nxt = RESP;
      RESP:    if (rsp_fire)  state_nxt = req_fire ? desc_tgt : IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    beat_ready = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE:             req_ready  = 1'b1;
      WAIT_LO, WAIT_HI: beat_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = bus.rsp_ready;
      end
      default: ;
    endcase
  end

  load_data_extract #(
    .DATA_WIDTH (DW)
  ) u_extract (
    .merged (merged),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .data   (extract_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q          <= '0;
      size_q         <= '0;
      sign_q         <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q        <= 1'b0;
      err_q          <= 1'b0;
      lo_q           <= '0;
`else
      rsp_misalign_q <= 1'b0;
`endif
    end else begin
      if (req_fire) begin
        off_q          <= bus.req_offset;
        size_q         <= bus.req_size;
        sign_q         <= bus.req_sign;
        rsp_data_q     <= '0;
        rsp_err_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
        split_q        <= split_c;
`else
        rsp_misalign_q <= split_c;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      if (beat_fire && state == WAIT_LO) begin
        lo_q  <= bus.beat_data;
        err_q <= bus.beat_err;
      end
`endif
      // Any bus error on the load squashes the data.
      if (last_beat) begin
        rsp_err_q  <= err_fin;
        rsp_data_q <= err_fin ? '0 : extract_data;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.req_split    = split_c;
  assign bus.beat_ready   = beat_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
`ifdef MISALIGN_SPLIT_EN
  assign bus.rsp_misalign = 1'b0;
`else
  assign bus.rsp_misalign = rsp_misalign_q;
`endif

endmodule

// File: tb/tb_memory_load_align.sv
// Randomized and directed bench for memory_load_align (DATA_WIDTH=64) against
// a byte-arithmetic reference model; works with or without MISALIGN_SPLIT_EN.
module tb_memory_load_align;

  localparam int unsigned DW = 64;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  memory_load_align_if #(.DATA_WIDTH(DW)) bus ();

  memory_load_align #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  // Little-endian byte window starting at 'off' over the two beats.
  function automatic logic [63:0] model(input logic [2:0] off, input logic [1:0] size,
                                        input logic sign, input logic [63:0] lo,
                                        input logic [63:0] hi);
    logic [127:0] m;
    logic [63:0]  v, mask;
    int           nb;
    m  = {hi, lo} >> (int'(off) * 8);
    v  = m[63:0];
    nb = 8 * nbytes(size);
    if (nb < 64) begin
      mask = (64'd1 << nb) - 64'd1;
      v    = v & mask;
      if (sign && ((v >> (nb - 1)) & 64'd1) != 64'd0) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic do_load(input logic [2:0] off, input logic [1:0] size, input logic sign,
                         input logic [63:0] lo, input logic [63:0] hi,
                         input logic elo, input logic ehi, input int stall);
    bit          exp_split, mis, exp_e;
    logic [63:0] exp_d;
    int          n;
    exp_split = (int'(off) + nbytes(size)) > 8;
    mis       = exp_split && !SPLIT_EN;
    exp_e     = mis ? 1'b0 : (elo | (exp_split & ehi));
    exp_d     = (mis || exp_e) ? 64'd0 : model(off, size, sign, lo, hi);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_offset = off;
    bus.req_size   = size;
    bus.req_sign   = sign;
    bus.beat_valid = 1'b1;
    bus.beat_data  = ~lo;
    bus.beat_err   = 1'b1;
    #1 check("req_split", 64'(bus.req_split), 64'(exp_split));
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      #1 n++;
    end
    check("req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_err   = 1'b0;
    #1;
    if (mis) begin
      check("mis_beat_ready", 64'(bus.beat_ready), 64'd0);
    end else begin
      check("beat_ready_lo", 64'(bus.beat_ready), 64'd1);
      bus.beat_valid = 1'b1;
      bus.beat_data  = lo;
      bus.beat_err   = elo;
      @(posedge clk);
      @(negedge clk);
      if (exp_split) begin
        #1 check("beat_ready_hi", 64'(bus.beat_ready), 64'd1);
        check("rsp_early", 64'(bus.rsp_valid), 64'd0);
        bus.beat_data = hi;
        bus.beat_err  = ehi;
        @(posedge clk);
        @(negedge clk);
      end
      bus.beat_valid = 1'b0;
      bus.beat_err   = 1'b0;
      #1;
    end
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_data", bus.rsp_data, exp_d);
    check("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
    check("rsp_misalign", 64'(bus.rsp_misalign), 64'(mis));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      #1 check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_data", bus.rsp_data, exp_d);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 check("rsp_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d1;
    bus.req_valid  = 1'b0;
    bus.req_offset = '0;
    bus.req_size   = '0;
    bus.req_sign   = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    bus.beat_err   = 1'b0;
    bus.rsp_ready  = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_rsp_misalign", 64'(bus.rsp_misalign), 64'd0);
    check("rst_beat_ready", 64'(bus.beat_ready), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the load-return scenarios.
    do_load(3'd3, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 1'b0, 1'b0, 1);
    do_load(3'd7, 2'd1, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 1'b0, 1'b0, 0);
    do_load(3'd6, 2'd2, 1'b1, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 1'b1, 1'b0, 0);
    do_load(3'd4, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 0);
    do_load(3'd0, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 64'd0, 1'b0, 1'b0, 0);

    // Stall then zero-bubble back-to-back acceptance.
    d1 = {$urandom, $urandom};
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_offset = 3'd0; bus.req_size = 2'd3; bus.req_sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.beat_valid = 1'b1; bus.beat_data = d1;
    @(posedge clk);
    @(negedge clk);
    bus.beat_valid = 1'b0;
    #1 check("b2b_valid", 64'(bus.rsp_valid), 64'd1);
    check("b2b_data", bus.rsp_data, d1);
    repeat (5) begin
      @(negedge clk);
      #1 check("b2b_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("b2b_hold_data", bus.rsp_data, d1);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_offset = 3'd0; bus.req_size = 2'd0; bus.req_sign = 1'b0;
    #1 check("b2b_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
    #1 check("b2b_beat_ready", 64'(bus.beat_ready), 64'd1);
    check("b2b_rsp_gap", 64'(bus.rsp_valid), 64'd0);
    bus.beat_valid = 1'b1; bus.beat_data = 64'h1234_5678_9ABC_DEA5;
    @(posedge clk);
    @(negedge clk);
    bus.beat_valid = 1'b0;
    #1 check("b2b_second_data", bus.rsp_data, 64'h0000_0000_0000_00A5);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Reset while a load is waiting on its beats.
    bus.req_valid  = 1'b1;
    bus.req_offset = SPLIT_EN ? 3'd7 : 3'd0;
    bus.req_size   = SPLIT_EN ? 2'd1 : 2'd2;
    bus.req_sign   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (SPLIT_EN) begin
      bus.beat_valid = 1'b1; bus.beat_data = 64'hDEAD_BEEF_0000_0000;
      @(posedge clk);
      @(negedge clk);
      bus.beat_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1 check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_beat_ready", 64'(bus.beat_ready), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    do_load(3'd0, 2'd0, 1'b0, 64'h0000_0000_0000_00FF, 64'd0, 1'b0, 1'b0, 0);

    // Randomized descriptors, data, errors and back-pressure.
    for (int t = 0; t < 40; t++) begin
      do_load(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
